// File: rtl/dmem_arb_pkg.sv
// dmem_arb_pkg: shared types and constants for the data-memory arbiter.
//   arb_state_t    - ownership state (IDLE, OWN0, OWN1)
//   PORT0/PORT1    - requester indices into the two-bit request/grant vectors
//   LOCK_MAX_DEF   - default maximum consecutive locked grants per owner
//   STARVE_MAX_DEF - default port-1 loss count before a forced port-1 win
//   misaligned()   - true when a byte address is not word aligned
package dmem_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        OWN0 = 2'd1,
        OWN1 = 2'd2
    } arb_state_t;

    localparam int unsigned PORT0 = 0;
    localparam int unsigned PORT1 = 1;

    localparam int unsigned LOCK_MAX_DEF   = 4;
    localparam int unsigned STARVE_MAX_DEF = 3;

    function automatic logic misaligned(input logic [1:0] lsb);
        return lsb != 2'b00;
    endfunction

endpackage

// File: rtl/dmem_arb_pick.sv
// dmem_arb_pick: combinational two-way picker.
//   req[1:0] - eligible requests (already masked for alignment/ownership)
//   pri      - 0: port 0 wins a tie, 1: port 1 wins a tie
//   gnt[1:0] - one-hot (or zero) grant
module dmem_arb_pick
    import dmem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       pri,
    output logic [1:0] gnt
);

    always_comb begin
        gnt = '0;
        if (req[PORT0] && (!req[PORT1] || !pri)) begin
            gnt[PORT0] = 1'b1;
        end else if (req[PORT1]) begin
            gnt[PORT1] = 1'b1;
        end
    end

endmodule

// File: rtl/dmem_arbiter.sv
// dmem_arbiter: shares one single-port data memory between the CPU load/store
// stage (port 0) and the DMA/debug loader (port 1). One access per cycle,
// combinational grant, registered read data/valid, misalignment error pulse,
// and bounded locked ownership for read-modify-write sequences.
//
// Ports:
//   clk, reset                    - clock, asynchronous active-high reset
//   reqN/weN/lockN/addrN/wdataN   - per-port request, write flag, lock, address, data
//   gntN                          - access performed this cycle (combinational)
//   rvalidN/rdataN                - registered read return (rvalid one-cycle pulse)
//   errN                          - misaligned request rejected (one-cycle pulse)
//   mem_access_addr/mem_write_data/mem_write_en/mem_read_en - memory strobes
//   mem_read_data                 - combinational memory read data
//
// Build option: define DMEM_ARB_RR_EN for round-robin idle arbitration
// (no starvation counter). Default is fixed priority to port 0 with a
// STARVE_MAX anti-starvation override for port 1.
module dmem_arbiter
    import dmem_arb_pkg::*;
#(
    parameter int unsigned ADDR_W     = 32,
    parameter int unsigned DATA_W     = 32,
    parameter int unsigned LOCK_MAX   = LOCK_MAX_DEF,
    parameter int unsigned STARVE_MAX = STARVE_MAX_DEF
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              req0,
    input  logic              req1,
    input  logic              we0,
    input  logic              we1,
    input  logic              lock0,
    input  logic              lock1,
    input  logic [ADDR_W-1:0] addr0,
    input  logic [ADDR_W-1:0] addr1,
    input  logic [DATA_W-1:0] wdata0,
    input  logic [DATA_W-1:0] wdata1,
    output logic              gnt0,
    output logic              gnt1,
    output logic              rvalid0,
    output logic              rvalid1,
    output logic [DATA_W-1:0] rdata0,
    output logic [DATA_W-1:0] rdata1,
    output logic              err0,
    output logic              err1,
    output logic [ADDR_W-1:0] mem_access_addr,
    output logic [DATA_W-1:0] mem_write_data,
    output logic              mem_write_en,
    output logic              mem_read_en,
    input  logic [DATA_W-1:0] mem_read_data
);

    localparam int unsigned  LCW         = $clog2(LOCK_MAX + 1);
    localparam logic [LCW-1:0] LOCK_LAST = LCW'(LOCK_MAX - 1);
    // With LOCK_MAX of 1 a locked grant is already the last one, so ownership
    // is never entered; the grant is treated as an immediate release.
    localparam logic         LOCK_SINGLE = (LOCK_MAX <= 1);

    arb_state_t     state_q;
    logic [LCW-1:0] lock_q;

    logic mis0, mis1, v0, v1;
    logic [1:0] mreq, pick_gnt;
    logic pri;
    logic lock_last;
    logic take0, take1, rel0, rel1;

    assign mis0 = req0 & misaligned(addr0[1:0]);
    assign mis1 = req1 & misaligned(addr1[1:0]);
    assign v0   = req0 & ~mis0;
    assign v1   = req1 & ~mis1;

    // While a port owns the memory, the other port's request is masked out.
    always_comb begin
        mreq = '0;
        case (state_q)
            IDLE:    begin mreq[PORT0] = v0; mreq[PORT1] = v1; end
            OWN0:    mreq[PORT0] = v0;
            OWN1:    mreq[PORT1] = v1;
            default: mreq = '0;
        endcase
    end

    dmem_arb_pick u_pick (
        .req (mreq),
        .pri (pri),
        .gnt (pick_gnt)
    );

    assign gnt0 = pick_gnt[PORT0] & ~reset;
    assign gnt1 = pick_gnt[PORT1] & ~reset;

    assign lock_last = (state_q == IDLE) ? LOCK_SINGLE : (lock_q == LOCK_LAST);
    assign take0 = gnt0 & lock0 & (state_q == IDLE) & ~LOCK_SINGLE;
    assign take1 = gnt1 & lock1 & (state_q == IDLE) & ~LOCK_SINGLE;
    // Release of a locked sequence: hands tie priority to the other port.
    assign rel0  = gnt0 & ((state_q == OWN0) ? (~lock0 | lock_last) : (lock0 & LOCK_SINGLE));
    assign rel1  = gnt1 & ((state_q == OWN1) ? (~lock1 | lock_last) : (lock1 & LOCK_SINGLE));

    always_comb begin
        mem_access_addr = '0;
        mem_write_data  = '0;
        mem_write_en    = 1'b0;
        mem_read_en     = 1'b0;
        if (gnt0) begin
            mem_access_addr = addr0;
            mem_write_data  = wdata0;
            mem_write_en    = we0;
            mem_read_en     = ~we0;
        end else if (gnt1) begin
            mem_access_addr = addr1;
            mem_write_data  = wdata1;
            mem_write_en    = we1;
            mem_read_en     = ~we1;
        end
    end

`ifdef DMEM_ARB_RR_EN
    // Last granted port loses the next tie; also covers the post-lock handoff
    // since the releasing owner was the last port granted.
    logic last1_q;

    assign pri = ~last1_q;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            last1_q <= 1'b1;
        end else if (gnt0) begin
            last1_q <= 1'b0;
        end else if (gnt1) begin
            last1_q <= 1'b1;
        end
    end
`else
    localparam int unsigned      SCW        = $clog2(STARVE_MAX + 1);
    localparam logic [SCW-1:0]   STARVE_LIM = SCW'(STARVE_MAX);

    logic [SCW-1:0] starve_q;
    logic           fav1_q;
    logic           starve_hit;

    assign starve_hit = (starve_q == STARVE_LIM);
    assign pri        = starve_hit | fav1_q;

    // fav1_q carries the post-lock handoff until the next contended idle cycle.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            starve_q <= '0;
            fav1_q   <= 1'b0;
        end else begin
            if (gnt1) begin
                starve_q <= '0;
            end else if (state_q == IDLE && v1 && !starve_hit) begin
                starve_q <= starve_q + SCW'(1);
            end

            if (rel0) begin
                fav1_q <= 1'b1;
            end else if (rel1) begin
                fav1_q <= 1'b0;
            end else if (state_q == IDLE && v0 && v1) begin
                fav1_q <= 1'b0;
            end
        end
    end
`endif

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state_q <= IDLE;
            lock_q  <= '0;
            rvalid0 <= 1'b0;
            rvalid1 <= 1'b0;
            rdata0  <= '0;
            rdata1  <= '0;
            err0    <= 1'b0;
            err1    <= 1'b0;
        end else begin
            rvalid0 <= gnt0 & ~we0;
            rvalid1 <= gnt1 & ~we1;
            if (gnt0 && !we0) rdata0 <= mem_read_data;
            if (gnt1 && !we1) rdata1 <= mem_read_data;
            err0 <= mis0;
            err1 <= mis1;

            case (state_q)
                IDLE: begin
                    if (take0) begin
                        state_q <= OWN0;
                        lock_q  <= LCW'(1);
                    end else if (take1) begin
                        state_q <= OWN1;
                        lock_q  <= LCW'(1);
                    end
                end
                OWN0: begin
                    if (rel0) begin
                        state_q <= IDLE;
                        lock_q  <= '0;
                    end else if (gnt0) begin
                        lock_q  <= lock_q + LCW'(1);
                    end
                end
                OWN1: begin
                    if (rel1) begin
                        state_q <= IDLE;
                        lock_q  <= '0;
                    end else if (gnt1) begin
                        lock_q  <= lock_q + LCW'(1);
                    end
                end
                default: begin
                    state_q <= IDLE;
                    lock_q  <= '0;
                end
            endcase
        end
    end

endmodule

// File: tb/tb_dmem_arbiter.sv
// tb_dmem_arbiter: directed self-checking bench for dmem_arbiter with a
// word-addressed memory model and per-port read-data scoreboards.
// Arbitration expectations follow DMEM_ARB_RR_EN when it is defined.
module tb_dmem_arbiter;

    logic        clk = 1'b0;
    logic        reset;
    logic        req0, req1, we0, we1, lock0, lock1;
    logic [31:0] addr0, addr1, wdata0, wdata1;
    logic        gnt0, gnt1, rvalid0, rvalid1, err0, err1;
    logic [31:0] rdata0, rdata1;
    logic [31:0] mem_access_addr, mem_write_data, mem_read_data;
    logic        mem_write_en, mem_read_en;

    int checks   = 0;
    int failures = 0;

    logic [31:0] mem [0:255];
    logic [31:0] ref_mem [logic [31:0]];
    logic [31:0] q0 [$];
    logic [31:0] q1 [$];
    logic [31:0] last_rd0 = '0;
    logic [31:0] last_rd1 = '0;

    always #5 clk = ~clk;

    dmem_arbiter #(
        .ADDR_W     (32),
        .DATA_W     (32),
        .LOCK_MAX   (4),
        .STARVE_MAX (3)
    ) dut (
        .clk             (clk),
        .reset           (reset),
        .req0            (req0),
        .req1            (req1),
        .we0             (we0),
        .we1             (we1),
        .lock0           (lock0),
        .lock1           (lock1),
        .addr0           (addr0),
        .addr1           (addr1),
        .wdata0          (wdata0),
        .wdata1          (wdata1),
        .gnt0            (gnt0),
        .gnt1            (gnt1),
        .rvalid0         (rvalid0),
        .rvalid1         (rvalid1),
        .rdata0          (rdata0),
        .rdata1          (rdata1),
        .err0            (err0),
        .err1            (err1),
        .mem_access_addr (mem_access_addr),
        .mem_write_data  (mem_write_data),
        .mem_write_en    (mem_write_en),
        .mem_read_en     (mem_read_en),
        .mem_read_data   (mem_read_data)
    );

    function automatic logic [31:0] pat(input logic [31:0] a);
        return 32'hC0DE_0000 ^ a;
    endfunction

    function automatic logic [31:0] exp_rd(input logic [31:0] a);
        if (ref_mem.exists(a)) return ref_mem[a];
        return pat(a);
    endfunction

    assign mem_read_data = mem[mem_access_addr[9:2]];
    always @(posedge clk) if (mem_write_en) mem[mem_access_addr[9:2]] <= mem_write_data;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    // Called at posedge+1: drives one cycle, checks grant/strobes at the
    // falling edge, then checks the registered returns after the next edge.
    task automatic drive(input string tag,
                         input logic r0, input logic w0, input logic l0,
                         input logic [31:0] a0, input logic [31:0] d0,
                         input logic r1, input logic w1, input logic l1,
                         input logic [31:0] a1, input logic [31:0] d1,
                         input logic e0, input logic e1);
        logic pv0, pv1, ee0, ee1;
        logic [31:0] ea, ed;
        req0 = r0; we0 = w0; lock0 = l0; addr0 = a0; wdata0 = d0;
        req1 = r1; we1 = w1; lock1 = l1; addr1 = a1; wdata1 = d1;
        #4;
        chk({tag, ".gnt0"}, 32'(gnt0), 32'(e0));
        chk({tag, ".gnt1"}, 32'(gnt1), 32'(e1));
        ea = e0 ? a0 : (e1 ? a1 : 32'h0);
        ed = e0 ? d0 : (e1 ? d1 : 32'h0);
        chk({tag, ".mem_addr"}, mem_access_addr, ea);
        chk({tag, ".mem_wdata"}, mem_write_data, ed);
        chk({tag, ".mem_we"}, 32'(mem_write_en), 32'((e0 & w0) | (e1 & w1)));
        chk({tag, ".mem_re"}, 32'(mem_read_en), 32'((e0 & ~w0) | (e1 & ~w1)));
        pv0 = e0 & ~w0;
        pv1 = e1 & ~w1;
        if (pv0) q0.push_back(exp_rd(a0));
        if (pv1) q1.push_back(exp_rd(a1));
        if (e0 & w0) ref_mem[a0] = d0;
        if (e1 & w1) ref_mem[a1] = d1;
        ee0 = r0 & (a0[1:0] != 2'b00);
        ee1 = r1 & (a1[1:0] != 2'b00);
        @(posedge clk);
        #1;
        chk({tag, ".rvalid0"}, 32'(rvalid0), 32'(pv0));
        chk({tag, ".rvalid1"}, 32'(rvalid1), 32'(pv1));
        chk({tag, ".err0"}, 32'(err0), 32'(ee0));
        chk({tag, ".err1"}, 32'(err1), 32'(ee1));
        if (pv0 && q0.size() > 0) last_rd0 = q0.pop_front();
        if (pv1 && q1.size() > 0) last_rd1 = q1.pop_front();
        chk({tag, ".rdata0"}, rdata0, last_rd0);
        chk({tag, ".rdata1"}, rdata1, last_rd1);
    endtask

    task automatic idle(input string tag);
        drive(tag, 0, 0, 0, 32'h0, 32'h0, 0, 0, 0, 32'h0, 32'h0, 0, 0);
    endtask

    initial begin
        #100000;
        $display("FAIL watchdog expired");
        $fatal(1, "timeout");
    end

    initial begin
        logic [3:0] g0s, g1s;
        for (int unsigned i = 0; i < 256; i++) mem[i] = pat(32'(i * 4));
        reset = 1'b1;
        req0 = 0; req1 = 0; we0 = 0; we1 = 0; lock0 = 0; lock1 = 0;
        addr0 = '0; addr1 = '0; wdata0 = '0; wdata1 = '0;

        // Reset state
        #7;
        chk("rst.gnt", 32'({gnt0, gnt1}), 32'h0);
        chk("rst.rvalid", 32'({rvalid0, rvalid1}), 32'h0);
        chk("rst.err", 32'({err0, err1}), 32'h0);
        chk("rst.rdata0", rdata0, 32'h0);
        chk("rst.rdata1", rdata1, 32'h0);
        chk("rst.strobes", 32'({mem_write_en, mem_read_en}), 32'h0);
        #2 reset = 1'b0;
        @(posedge clk); #1;

        // Write then read back on port 0
        drive("wr0", 1, 1, 0, 32'h10, 32'hA5A5_A5A5, 0, 0, 0, 32'h0, 32'h0, 1, 0);
        drive("rd0", 1, 0, 0, 32'h10, 32'h0, 0, 0, 0, 32'h0, 32'h0, 1, 0);
        idle("idle0");

        // Continuous contention from both ports
`ifdef DMEM_ARB_RR_EN
        g1s = 4'b0101;
`else
        g1s = 4'b1000;
`endif
        for (int i = 0; i < 4; i++) begin
            g0s = ~g1s;
            drive($sformatf("cont%0d", i), 1, 0, 0, 32'h20, 32'h0, 1, 0, 0, 32'h40, 32'h0,
                  g0s[i], g1s[i]);
        end
`ifdef DMEM_ARB_RR_EN
        drive("cont4", 1, 0, 0, 32'h20, 32'h0, 1, 0, 0, 32'h40, 32'h0, 0, 1);
`else
        drive("cont4", 1, 0, 0, 32'h20, 32'h0, 1, 0, 0, 32'h40, 32'h0, 1, 0);
`endif
        idle("idle1");

        // Port 1 locked for LOCK_MAX grants while port 0 waits
        drive("lk1a", 0, 0, 0, 32'h24, 32'h0, 1, 0, 1, 32'h44, 32'h0, 0, 1);
        drive("lk1b", 1, 0, 0, 32'h24, 32'h0, 1, 1, 1, 32'h44, 32'h1111_2222, 0, 1);
        drive("lk1c", 1, 0, 0, 32'h24, 32'h0, 1, 0, 1, 32'h44, 32'h0, 0, 1);
        drive("lk1d", 1, 0, 0, 32'h24, 32'h0, 1, 0, 1, 32'h48, 32'h0, 0, 1);
        drive("lk1e", 1, 0, 0, 32'h24, 32'h0, 1, 0, 1, 32'h48, 32'h0, 1, 0);
        idle("idle2");

        // Port 0 lock held without request, then released
        drive("lk0a", 1, 1, 1, 32'h50, 32'h3333_4444, 0, 0, 0, 32'h0, 32'h0, 1, 0);
        drive("lk0b", 0, 0, 1, 32'h50, 32'h0, 1, 0, 0, 32'h54, 32'h0, 0, 0);
        drive("lk0c", 1, 1, 0, 32'h58, 32'h5555_6666, 1, 0, 0, 32'h54, 32'h0, 1, 0);
        drive("lk0d", 1, 0, 0, 32'h50, 32'h0, 1, 0, 0, 32'h58, 32'h0, 0, 1);
        drive("lk0e", 1, 0, 0, 32'h50, 32'h0, 1, 0, 0, 32'h58, 32'h0, 1, 0);
        idle("idle3");

        // Misaligned requests
        drive("mis1", 1, 0, 0, 32'h28, 32'h0, 1, 0, 0, 32'h6, 32'h0, 1, 0);
        drive("mis0", 1, 0, 0, 32'h2, 32'h0, 1, 0, 0, 32'h48, 32'h0, 0, 1);
        drive("mis1a", 0, 0, 0, 32'h0, 32'h0, 1, 1, 0, 32'h6, 32'hDEAD_BEEF, 0, 0);
        idle("idle4");

        // Reset during port-0 ownership with a read in flight
        req0 = 1; we0 = 0; lock0 = 1; addr0 = 32'h30; wdata0 = '0;
        req1 = 0; we1 = 0; lock1 = 0; addr1 = 32'h4C; wdata1 = '0;
        #4;
        chk("rstlk.gnt0", 32'(gnt0), 32'h1);
        #2 reset = 1'b1;
        #1;
        chk("rstlk.gnt0_rst", 32'(gnt0), 32'h0);
        @(posedge clk); #1;
        chk("rstlk.rvalid0", 32'(rvalid0), 32'h0);
        chk("rstlk.rdata0", rdata0, 32'h0);
        chk("rstlk.err0", 32'(err0), 32'h0);
        last_rd0 = '0;
        last_rd1 = '0;
        req0 = 0; lock0 = 0;
        #3 reset = 1'b0;
        @(posedge clk); #1;
        drive("rstlk.req1", 0, 0, 0, 32'h30, 32'h0, 1, 0, 0, 32'h4C, 32'h0, 0, 1);
        drive("rstlk.both", 1, 0, 0, 32'h30, 32'h0, 1, 0, 0, 32'h4C, 32'h0, 1, 0);
        idle("idle5");

        chk("sb.q0_empty", 32'(q0.size()), 32'h0);
        chk("sb.q1_empty", 32'(q1.size()), 32'h0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
